// File: rtl/if_id_stage.sv
// Fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Define IF_PERF_CNT_EN to add the StallCount/FlushCount performance counters.
module if_id_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0040_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0004,
   parameter logic [31:0] BUBBLE     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  PCSrc,
   input  logic        DataHazard,
   input  logic        ExceptionReq,
   input  logic [31:0] JrTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] PC,
   output logic [31:0] IF_ID_Instruction,
   output logic [31:0] IF_ID_PC4,
   output logic        IF_ID_Valid,
   output logic        AlignFault
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] StallCount,
   output logic [31:0] FlushCount
`endif
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic        align_fault_q, align_fault_d;

   logic [31:0] pc_plus4;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] jr_tgt;
   logic        stall;
   logic        redirect;

   assign pc_plus4 = pc_q + 32'd4;
   assign br_tgt   = pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign j_tgt    = {pc4_q[31:28], instr_q[25:0], 2'b00};
   assign jr_tgt   = {JrTarget[31:2], 2'b00};

   assign stall    = DataHazard & ~ExceptionReq;
   // A bubble in IF/ID cannot redirect; its PCSrc is treated as sequential.
   assign redirect = ~ExceptionReq & ~DataHazard & valid_q &
                     (PCSrc == 3'b001 || PCSrc == 3'b010 || PCSrc == 3'b011);

   always_comb begin
      pc_d          = pc_plus4;
      instr_d       = Instruction;
      pc4_d         = pc_plus4;
      valid_d       = 1'b1;
      align_fault_d = 1'b0;
      if (ExceptionReq) begin
         pc_d    = EXC_VECTOR;
         instr_d = BUBBLE;
         pc4_d   = 32'h0;
         valid_d = 1'b0;
      end else if (stall) begin
         pc_d    = pc_q;
         instr_d = instr_q;
         pc4_d   = pc4_q;
         valid_d = valid_q;
      end else if (redirect) begin
         instr_d = BUBBLE;
         pc4_d   = 32'h0;
         valid_d = 1'b0;
         unique case (PCSrc)
            3'b001:  pc_d = br_tgt;
            3'b010:  pc_d = j_tgt;
            default: begin
               pc_d          = jr_tgt;
               align_fault_d = |JrTarget[1:0];
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         instr_q       <= BUBBLE;
         pc4_q         <= 32'h0;
         valid_q       <= 1'b0;
         align_fault_q <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         pc4_q         <= pc4_d;
         valid_q       <= valid_d;
         align_fault_q <= align_fault_d;
      end
   end

   assign PC                = pc_q;
   assign IF_ID_Instruction = instr_q;
   assign IF_ID_PC4         = pc4_q;
   assign IF_ID_Valid       = valid_q;
   assign AlignFault        = align_fault_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
      if (ExceptionReq || redirect) flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a behavioural model of the fetch stage.
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  PCSrc;
   logic        DataHazard;
   logic        ExceptionReq;
   logic [31:0] JrTarget;
   logic [31:0] Instruction;
   logic [31:0] PC;
   logic [31:0] IF_ID_Instruction;
   logic [31:0] IF_ID_PC4;
   logic        IF_ID_Valid;
   logic        AlignFault;
`ifdef IF_PERF_CNT_EN
   logic [31:0] StallCount;
   logic [31:0] FlushCount;
`endif

   if_id_stage dut (
      .clk               (clk),
      .reset             (reset),
      .PCSrc             (PCSrc),
      .DataHazard        (DataHazard),
      .ExceptionReq      (ExceptionReq),
      .JrTarget          (JrTarget),
      .Instruction       (Instruction),
      .PC                (PC),
      .IF_ID_Instruction (IF_ID_Instruction),
      .IF_ID_PC4         (IF_ID_PC4),
      .IF_ID_Valid       (IF_ID_Valid),
      .AlignFault        (AlignFault)
`ifdef IF_PERF_CNT_EN
      ,
      .StallCount        (StallCount),
      .FlushCount        (FlushCount)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [31:0] m_pc, m_instr, m_pc4, m_sc, m_fc;
   logic        m_valid, m_af;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0040_0000; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_af = 1'b0; m_sc = 32'h0; m_fc = 32'h0;
   endtask

   task automatic compare_all();
      check("pc", PC, m_pc);
      check("ifid_instr", IF_ID_Instruction, m_instr);
      check("ifid_valid", {31'h0, IF_ID_Valid}, {31'h0, m_valid});
      check("align_fault", {31'h0, AlignFault}, {31'h0, m_af});
      if (m_valid) check("ifid_pc4", IF_ID_PC4, m_pc4);
`ifdef IF_PERF_CNT_EN
      check("stall_count", StallCount, m_sc);
      check("flush_count", FlushCount, m_fc);
`endif
   endtask

   // Apply one cycle of inputs, advance the model by the priority rules, then compare.
   task automatic step(input logic [2:0] src, input logic dh, input logic exc,
                       input logic [31:0] jr, input logic [31:0] instr);
      logic [31:0] imm_off;
      PCSrc = src; DataHazard = dh; ExceptionReq = exc; JrTarget = jr; Instruction = instr;
      @(posedge clk);
      imm_off = {{16{m_instr[15]}}, m_instr[15:0]} * 4;
      m_af = 1'b0;
      if (exc) begin
         m_pc = 32'h8000_0004; m_instr = 32'h0; m_valid = 1'b0; m_fc = m_fc + 1;
      end else if (dh) begin
         m_sc = m_sc + 1;
      end else if (m_valid && src >= 3'd1 && src <= 3'd3) begin
         if (src == 3'd1) m_pc = m_pc4 + imm_off;
         else if (src == 3'd2) m_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
         else begin
            m_pc = jr & 32'hFFFF_FFFC;
            m_af = (jr % 4) != 0;
         end
         m_instr = 32'h0; m_valid = 1'b0; m_fc = m_fc + 1;
      end else begin
         m_pc4 = m_pc + 4; m_instr = instr; m_valid = 1'b1; m_pc = m_pc + 4;
      end
      #1;
      compare_all();
   endtask

   initial begin
      reset = 1'b1; PCSrc = 3'b000; DataHazard = 1'b0; ExceptionReq = 1'b0;
      JrTarget = 32'h0; Instruction = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", PC, 32'h0040_0000);
      check("rst_instr", IF_ID_Instruction, 32'h0);
      check("rst_pc4", IF_ID_PC4, 32'h0);
      check("rst_valid", {31'h0, IF_ID_Valid}, 32'h0);
      check("rst_af", {31'h0, AlignFault}, 32'h0);
      #3 reset = 1'b0;

      // T1: sequential fetch
      step(3'b000, 1'b0, 1'b0, 32'h0, 32'h2008_0005);
      check("t1_pc", PC, 32'h0040_0004);
      check("t1_instr", IF_ID_Instruction, 32'h2008_0005);
      check("t1_pc4", IF_ID_PC4, 32'h0040_0004);
      check("t1_valid", {31'h0, IF_ID_Valid}, 32'h1);
      step(3'b000, 1'b0, 1'b0, 32'h0, 32'h0000_1234);
      check("t1_pc2", PC, 32'h0040_0008);

      // T2: three-cycle stall
      for (int i = 0; i < 3; i++) begin
         step(3'b001, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
         check("t2_hold_pc", PC, 32'h0040_0008);
         check("t2_hold_instr", IF_ID_Instruction, 32'h0000_1234);
      end
      step(3'b000, 1'b0, 1'b0, 32'h0, 32'h0000_5678);
      check("t2_resume_pc", PC, 32'h0040_000C);
`ifdef IF_PERF_CNT_EN
      check("t2_stall_count", StallCount, 32'd3);
`endif

      // T3: beq imm=FFFE from PC4=0x00400010, stalled then taken
      step(3'b000, 1'b0, 1'b0, 32'h0, 32'h1000_FFFE);
      check("t3_pc4", IF_ID_PC4, 32'h0040_0010);
      step(3'b001, 1'b1, 1'b0, 32'h0, 32'h1111_1111);
      check("t3_stalled_pc", PC, 32'h0040_0010);
      step(3'b001, 1'b0, 1'b0, 32'h0, 32'h1111_1111);
      check("t3_br_pc", PC, 32'h0040_0008);
      check("t3_br_valid", {31'h0, IF_ID_Valid}, 32'h0);

      // T4: J to 0x00400040, then misaligned JR
      step(3'b010, 1'b0, 1'b0, 32'h0, 32'h0810_0010);
      check("t4_bubble_noredirect_pc", PC, 32'h0040_000C);
      step(3'b010, 1'b0, 1'b0, 32'h0, 32'h2222_2222);
      check("t4_j_pc", PC, 32'h0040_0040);
      step(3'b000, 1'b0, 1'b0, 32'h0, 32'h0320_0008);
      step(3'b011, 1'b0, 1'b0, 32'h0040_0023, 32'h3333_3333);
      check("t4_jr_pc", PC, 32'h0040_0020);
      check("t4_af", {31'h0, AlignFault}, 32'h1);
      step(3'b000, 1'b0, 1'b0, 32'h0, 32'h4444_4444);
      check("t4_af_clear", {31'h0, AlignFault}, 32'h0);

      // T5: exception overrides stall and JR
      step(3'b011, 1'b1, 1'b1, 32'h0000_0003, 32'h5555_5555);
      check("t5_pc", PC, 32'h8000_0004);
      check("t5_valid", {31'h0, IF_ID_Valid}, 32'h0);
      check("t5_af", {31'h0, AlignFault}, 32'h0);
`ifdef IF_PERF_CNT_EN
      check("t5_flush_count", FlushCount, 32'd4);
`endif

      // Randomised run
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] src;
         src = (($urandom % 3) == 0) ? 3'($urandom) : 3'b000;
         step(src, ($urandom % 4) == 0, ($urandom % 25) == 0, $urandom, $urandom);
      end

      // T6: async reset asserted mid-stall between edges
      step(3'b000, 1'b1, 1'b0, 32'h0, 32'h0);
      step(3'b001, 1'b1, 1'b0, 32'h0, 32'h0);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("t6_pc", PC, 32'h0040_0000);
      check("t6_instr", IF_ID_Instruction, 32'h0);
      check("t6_pc4", IF_ID_PC4, 32'h0);
      check("t6_valid", {31'h0, IF_ID_Valid}, 32'h0);
      @(posedge clk);
      #3 reset = 1'b0;
      DataHazard = 1'b0;
      step(3'b000, 1'b0, 1'b0, 32'h0, 32'h2008_0005);
      check("t6_restart_pc", PC, 32'h0040_0004);
      check("t6_restart_pc4", IF_ID_PC4, 32'h0040_0004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
